// File: rtl/fetch_stage_pkg.sv
// Shared widths and reset address for the fetch stage and its neighbours.
package fetch_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] FS_RESET_PC     = 32'h1c00_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding SRAM request, single output slot,
// redirect from decode cancels any in-flight wrong-path fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FS_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fs_state_e;

  fs_state_e   state;
  fs_state_e   state_nxt;
  logic [31:0] next_pc;
  logic [31:0] req_pc;
  logic        cancel;
  logic        fs_valid;
  logic [31:0] fs_inst;
  logic [31:0] fs_pc;

  logic        br_taken;
  logic [31:0] br_target;
  logic        issue;
  logic        accept;
  logic        resp;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // The request is raised from IDLE in the same cycle the slot frees up, so the
  // first fetch after reset and after a redirect costs no extra cycle.
  assign issue = (state == IDLE) && !reset && !br_taken && (!fs_valid || ds_allowin);

  assign inst_sram_req  = issue || (state == REQ);
  assign inst_sram_addr = (state == IDLE) ? next_pc : req_pc;
  assign accept         = inst_sram_req && inst_sram_addr_ok;
  assign resp           = (state == RESP) && inst_sram_data_ok;

  assign fs_to_ds_valid = fs_valid && !br_taken;
  assign fs_to_ds_bus   = {fs_inst, fs_pc};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = accept ? RESP : REQ;
      end
      REQ: begin
        if (accept) state_nxt = RESP;
      end
      RESP: begin
        if (resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      next_pc  <= RESET_PC;
      req_pc   <= '0;
      cancel   <= 1'b0;
      fs_valid <= 1'b0;
      fs_inst  <= '0;
      fs_pc    <= '0;
    end else begin
      state <= state_nxt;

      if (issue) req_pc <= next_pc;

      // Once cancel is set next_pc already holds the redirect target, so the
      // late acceptance of the wrong-path request must not bump it.
      if (br_taken) begin
        next_pc <= br_target;
      end else if (accept && !cancel) begin
        next_pc <= inst_sram_addr + PC_STEP;
      end

      if (resp) begin
        cancel <= 1'b0;
      end else if (br_taken && (state != IDLE)) begin
        cancel <= 1'b1;
      end

      if (br_taken) begin
        fs_valid <= 1'b0;
      end else if (resp && !cancel) begin
        fs_valid <= 1'b1;
        fs_inst  <= inst_sram_rdata;
        fs_pc    <= req_pc;
      end else if (fs_to_ds_valid && ds_allowin) begin
        fs_valid <= 1'b0;
      end
    end
  end

endmodule
